regfile_wb_ctrl: RTL and testbench
==================================

# regfile_wb_ctrl

Write-back controller for the 32x32 register file. It merges single-cycle ALU results and long-latency LSU/mul-div results onto the file's single write port (`reg_w`/`rd_num`/`rd_data`) and buffers LSU results in a 2-entry FIFO. It keeps a pending-destination scoreboard so decode can stall on RAW/WAW hazards. It also flags same-cycle bypass, because register-file writes land only at the next `posedge`.

## Interface
Parameters:
- `XLEN`, 32, data width
- `NREG`, 32, architectural register count; register 0 is hardwired zero

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-high
- `alu_valid`  in  1  ALU result present this cycle; no backpressure
- `alu_rd`  in  5  ALU destination
- `alu_data`  in  XLEN  ALU result
- `lsu_valid`  in  1  long-latency result offered
- `lsu_ready`  out  1  FIFO can accept a result
- `lsu_rd`  in  5  long-latency destination
- `lsu_data`  in  XLEN  long-latency result
- `issue_valid`  in  1  decode issues an instruction this cycle
- `issue_long`  in  1  issued instruction completes via the LSU path
- `issue_rd`  in  5  destination of the issued instruction
- `rs1num`, `rs2num`  in  5 each  source registers being read by decode
- `hazard`  out  1  decode must stall
- `fwd_rs1`, `fwd_rs2`  out  1 each  selects `rd_data` in place of the register-file read
- `reg_w`  out  1  register-file write enable
- `rd_num`  out  5  register-file write address
- `rd_data`  out  XLEN  register-file write data
- `lsu_full`  out  1  FIFO holds 2 entries

## Operation
- **FIFO:** 2 entries, each holding {rd, data}.
  - `lsu_ready = (count != 2)`, computed from registered count.
  - A push occurs when `lsu_valid & lsu_ready`.
  - There is no push when full, even if a pop happens in the same cycle.
- **Arbitration (each cycle):**
  - If `alu_valid`, the ALU result is selected and the FIFO does not pop.
  - Otherwise, if the FIFO is non-empty, the head is selected and popped.
  - Otherwise, nothing is selected.
  - The ALU always wins. LSU starvation is handled upstream using `lsu_full`.
- **Write port (registered):**
  - When a result is selected: `reg_w <= (sel_rd != 0)`, `rd_num <= sel_rd`, `rd_data <= sel_data`.
  - When nothing is selected: `reg_w <= 0`, and `rd_num`/`rd_data` hold their previous values.
  - A selected entry with rd = 0 is still popped, but no write is issued.
- **Scoreboard:** a `pending` bit vector of NREG bits; bit 0 is always 0.
  - Set `pending[issue_rd]` when `issue_valid & issue_long & issue_rd != 0 & !hazard`.
  - Clear `pending[rd]` when a FIFO entry is popped.
  - If set and clear hit the same register in one cycle, the set wins.
- **Hazard (combinational from registered state):**
  - `hazard = (pending[rs1num] & rs1num!=0) | (pending[rs2num] & rs2num!=0) | (issue_valid & pending[issue_rd] & issue_rd!=0)`.
- **Forwarding:**
  - `fwd_rs1 = reg_w & (rd_num == rs1num) & (rs1num != 0)`.
  - `fwd_rs2` is the same, using `rs2num`.
- The FIFO uses wrap-around pointers of 1 bit each plus a 2-bit count. A simultaneous push and pop when count = 1 leaves count = 1.

## Timing
- **Reset values:** `reg_w=0`, `rd_num=0`, `rd_data=0`, `lsu_ready=1`, `lsu_full=0`, `hazard=0`, `fwd_*=0`. FIFO is empty and `pending` is all 0.
- **Reset mid-operation:** buffered results are discarded and no write is issued on the cycle after reset.
- **ALU result latency:** `alu_valid` in cycle N gives `reg_w` in N+1; the register-file update is visible in N+2.
- **LSU result latency (FIFO empty, no ALU):** accepted in N, written in N+1 (head is visible to arbitration the cycle after the push), visible on `reg_w` in N+2.
- **Scoreboard clear:** a pending bit clears at the edge where the write is registered. In the cycle `reg_w` is high, decode reads via `fwd_*`.
- `lsu_ready` and `lsu_full` change only on clock edges.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `alu_valid=1` → all outputs at reset values, and `reg_w=0` in the first cycle after release.
- **ALU write:** `alu_valid=1`, `alu_rd=5`, `alu_data=32'hDEADBEEF` → next cycle `reg_w=1`, `rd_num=5`, `rd_data=32'hDEADBEEF`. With `rs1num=5` that cycle, `fwd_rs1=1`.
- **Contention:** LSU pushes rd=7/`32'h11`, rd=8/`32'h22` while `alu_valid` is held for 3 cycles → `lsu_full=1` and `lsu_ready=0`. After the ALU drops, writes appear as rd 7 then rd 8 in order, and `lsu_ready` returns to 1.
- **Scoreboard:** issue long rd=3 → `hazard=1` with `rs2num=3`. LSU result for rd=3 arrives → `hazard` falls on the edge where `reg_w` rises for rd 3.
- **rd=0:** ALU rd=0 and LSU rd=0 results → `reg_w` stays 0, FIFO drains, and an issue with `issue_rd=0` never raises `hazard`.
- **Set/clear collision:** pop for rd=9 in the same cycle as a new long issue to rd=9 → `pending[9]` remains 1 and `hazard=1` for `rs1num=9`.

Source files
------------

// File: rtl/regfile_wb_ctrl_if.sv
// Bundles the write-back controller's result, issue, hazard and write-port
// signals. Decode/execute side drives through master; the controller is slave.
interface regfile_wb_ctrl_if #(
    parameter int XLEN = 32
);
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;

    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            lsu_full;

    logic            issue_valid;
    logic            issue_long;
    logic [4:0]      issue_rd;
    logic [4:0]      rs1num;
    logic [4:0]      rs2num;
    logic            hazard;
    logic            fwd_rs1;
    logic            fwd_rs2;

    logic            reg_w;
    logic [4:0]      rd_num;
    logic [XLEN-1:0] rd_data;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output issue_valid, issue_long, issue_rd, rs1num, rs2num,
        input  lsu_ready, lsu_full, hazard, fwd_rs1, fwd_rs2,
        input  reg_w, rd_num, rd_data
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  issue_valid, issue_long, issue_rd, rs1num, rs2num,
        output lsu_ready, lsu_full, hazard, fwd_rs1, fwd_rs2,
        output reg_w, rd_num, rd_data
    );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back controller: merges ALU and long-latency results onto
// the single write port, buffers long-latency results in a 2-entry FIFO, tracks
// pending long-latency destinations for decode stalls, and flags bypass of the
// value currently being written.
module regfile_wb_ctrl #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input logic             clk,
    input logic             rst,
    regfile_wb_ctrl_if.slave bus
);

    // FIFO storage and control
    logic [4:0]      r_fifo_rd   [2];
    logic [XLEN-1:0] r_fifo_data [2];
    logic            r_wptr;
    logic            r_rptr;
    logic [1:0]      r_count;

    // Registered write port
    logic            r_reg_w;
    logic [4:0]      r_rd_num;
    logic [XLEN-1:0] r_rd_data;

    // Pending-destination scoreboard
    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_pending_next;

    logic            w_push;
    logic            w_pop;
    logic            w_sel_valid;
    logic [4:0]      w_sel_rd;
    logic [XLEN-1:0] w_sel_data;
    logic [4:0]      w_head_rd;
    logic            w_set;
    logic            w_hazard;

    assign w_head_rd     = r_fifo_rd[r_rptr];
    assign bus.lsu_ready = (r_count != 2'd2);
    assign bus.lsu_full  = (r_count == 2'd2);
    assign w_push        = bus.lsu_valid & (r_count != 2'd2);

    // Arbitration: ALU always wins, otherwise drain the FIFO head
    always_comb begin
        w_pop       = 1'b0;
        w_sel_valid = 1'b0;
        w_sel_rd    = '0;
        w_sel_data  = '0;
        if (bus.alu_valid) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = bus.alu_rd;
            w_sel_data  = bus.alu_data;
        end else if (r_count != 2'd0) begin
            w_pop       = 1'b1;
            w_sel_valid = 1'b1;
            w_sel_rd    = w_head_rd;
            w_sel_data  = r_fifo_data[r_rptr];
        end
    end

    // FIFO payload storage; contents are don't-care while not counted
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wptr]   <= bus.lsu_rd;
            r_fifo_data[r_wptr] <= bus.lsu_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Register-file write port; address/data hold when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_w   <= 1'b0;
            r_rd_num  <= '0;
            r_rd_data <= '0;
        end else if (w_sel_valid) begin
            r_reg_w   <= (w_sel_rd != 5'd0);
            r_rd_num  <= w_sel_rd;
            r_rd_data <= w_sel_data;
        end else begin
            r_reg_w   <= 1'b0;
        end
    end

    // Hazard from registered scoreboard state only
    always_comb begin
        w_hazard = (r_pending[bus.rs1num] & (bus.rs1num != 5'd0))
                 | (r_pending[bus.rs2num] & (bus.rs2num != 5'd0))
                 | (bus.issue_valid & r_pending[bus.issue_rd] & (bus.issue_rd != 5'd0));
    end

    assign w_set = bus.issue_valid & bus.issue_long & (bus.issue_rd != 5'd0) & ~w_hazard;

    // Next scoreboard: clear on pop applied before set so a same-register set wins
    always_comb begin
        w_pending_next = r_pending;
        if (w_pop) w_pending_next[w_head_rd] = 1'b0;
        if (w_set) w_pending_next[bus.issue_rd] = 1'b1;
        w_pending_next[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (rst) r_pending <= '0;
        else     r_pending <= w_pending_next;
    end

    assign bus.hazard  = w_hazard;
    assign bus.fwd_rs1 = r_reg_w & (r_rd_num == bus.rs1num) & (bus.rs1num != 5'd0);
    assign bus.fwd_rs2 = r_reg_w & (r_rd_num == bus.rs2num) & (bus.rs2num != 5'd0);
    assign bus.reg_w   = r_reg_w;
    assign bus.rd_num  = r_rd_num;
    assign bus.rd_data = r_rd_data;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed scenarios plus a
// randomized run, all compared against a queue-based behavioural model.
module tb_regfile_wb_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    regfile_wb_ctrl_if #(.XLEN(32)) bus ();

    regfile_wb_ctrl #(.XLEN(32), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural model: results queue, pending set, expected write port
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        m_q[$];
    bit          m_pend [32];
    logic        m_reg_w   = 1'b0;
    logic [4:0]  m_rd_num  = '0;
    logic [31:0] m_rd_data = '0;

    function automatic bit m_hazard();
        return (m_pend[bus.rs1num] && bus.rs1num != 0) ||
               (m_pend[bus.rs2num] && bus.rs2num != 0) ||
               (bus.issue_valid && m_pend[bus.issue_rd] && bus.issue_rd != 0);
    endfunction

    // {reg_w, rd_num, rd_data, lsu_ready, lsu_full, hazard, fwd_rs1, fwd_rs2}
    function automatic logic [42:0] exp_vec();
        logic f1, f2;
        f1 = m_reg_w && (m_rd_num == bus.rs1num) && (bus.rs1num != 0);
        f2 = m_reg_w && (m_rd_num == bus.rs2num) && (bus.rs2num != 0);
        return {m_reg_w, m_rd_num, m_rd_data, logic'(m_q.size() != 2),
                logic'(m_q.size() == 2), logic'(m_hazard()), f1, f2};
    endfunction

    function automatic logic [42:0] obs_vec();
        return {bus.reg_w, bus.rd_num, bus.rd_data, bus.lsu_ready,
                bus.lsu_full, bus.hazard, bus.fwd_rs1, bus.fwd_rs2};
    endfunction

    task automatic model_clock();
        bit   push, haz;
        ent_t e;
        if (rst) begin
            m_q.delete();
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_reg_w = 1'b0; m_rd_num = '0; m_rd_data = '0;
            return;
        end
        haz  = m_hazard();
        push = bus.lsu_valid && (m_q.size() < 2);
        if (bus.alu_valid) begin
            m_reg_w = (bus.alu_rd != 0); m_rd_num = bus.alu_rd; m_rd_data = bus.alu_data;
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_reg_w = (e.rd != 0); m_rd_num = e.rd; m_rd_data = e.data;
            m_pend[e.rd] = 1'b0;
        end else begin
            m_reg_w = 1'b0;
        end
        if (bus.issue_valid && bus.issue_long && bus.issue_rd != 0 && !haz)
            m_pend[bus.issue_rd] = 1'b1;
        if (push) begin
            e.rd = bus.lsu_rd; e.data = bus.lsu_data;
            m_q.push_back(e);
        end
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
        bus.issue_valid = 0; bus.issue_long = 0; bus.issue_rd = 0;
        bus.rs1num = 0; bus.rs2num = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'h1234_5678;
        bus.lsu_valid = 1; bus.lsu_rd = 4; bus.lsu_data = 32'h44;
        tick(); tick();
        rst = 0;
        bus.lsu_valid = 0;
        #1;
        if ({bus.reg_w, bus.rd_num, bus.rd_data} !== 38'd0) begin
            errors++; $display("FAIL reset_wport: got %h want 0", {bus.reg_w, bus.rd_num, bus.rd_data});
        end
        checks++;
        if ({bus.lsu_ready, bus.lsu_full, bus.hazard, bus.fwd_rs1, bus.fwd_rs2} !== 5'b10000) begin
            errors++; $display("FAIL reset_flags: got %b want 10000",
                               {bus.lsu_ready, bus.lsu_full, bus.hazard, bus.fwd_rs1, bus.fwd_rs2});
        end
        checks++;
        tick();
        bus.alu_valid = 0;
        #1;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_release: got %h want %h", obs_vec(), exp_vec());
        end
        checks++;
        tick();
    endtask

    task automatic test_alu_write();
        idle_inputs();
        bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'hDEADBEEF;
        tick();
        bus.alu_valid = 0; bus.rs1num = 5;
        #1;
        if ({bus.reg_w, bus.rd_num, bus.rd_data, bus.fwd_rs1} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b1}) begin
            errors++; $display("FAIL alu_write: got %h want %h",
                {bus.reg_w, bus.rd_num, bus.rd_data, bus.fwd_rs1}, {1'b1, 5'd5, 32'hDEADBEEF, 1'b1});
        end
        checks++;
        tick();
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL alu_idle: got %h want %h", obs_vec(), exp_vec());
        end
        checks++;
    endtask

    task automatic test_contention();
        idle_inputs();
        bus.alu_valid = 1; bus.alu_rd = 1; bus.alu_data = $urandom;
        bus.lsu_valid = 1; bus.lsu_rd = 7; bus.lsu_data = 32'h11;
        tick();
        bus.alu_data = $urandom;
        bus.lsu_rd = 8; bus.lsu_data = 32'h22;
        tick();
        // Third ALU cycle: offer a third result which must be refused
        bus.alu_data = $urandom;
        bus.lsu_rd = 10; bus.lsu_data = 32'h33;
        #1;
        if ({bus.lsu_full, bus.lsu_ready} !== 2'b10) begin
            errors++; $display("FAIL cont_full: got %b want 10", {bus.lsu_full, bus.lsu_ready});
        end
        checks++;
        tick();
        bus.lsu_valid = 0; bus.alu_valid = 0;
        tick();
        if ({bus.reg_w, bus.rd_num, bus.rd_data} !== {1'b1, 5'd7, 32'h11}) begin
            errors++; $display("FAIL cont_first: got %h want %h",
                {bus.reg_w, bus.rd_num, bus.rd_data}, {1'b1, 5'd7, 32'h11});
        end
        checks++;
        tick();
        if ({bus.reg_w, bus.rd_num, bus.rd_data, bus.lsu_ready} !== {1'b1, 5'd8, 32'h22, 1'b1}) begin
            errors++; $display("FAIL cont_second: got %h want %h",
                {bus.reg_w, bus.rd_num, bus.rd_data, bus.lsu_ready}, {1'b1, 5'd8, 32'h22, 1'b1});
        end
        checks++;
        tick();
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL cont_drained: got %h want %h", obs_vec(), exp_vec());
        end
        checks++;
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        bus.issue_valid = 1; bus.issue_long = 1; bus.issue_rd = 3;
        tick();
        idle_inputs();
        bus.rs2num = 3;
        #1;
        if (bus.hazard !== 1'b1) begin
            errors++; $display("FAIL sb_set: got %b want 1", bus.hazard);
        end
        checks++;
        bus.lsu_valid = 1; bus.lsu_rd = 3; bus.lsu_data = 32'h3333;
        tick();
        bus.lsu_valid = 0;
        #1;
        if (bus.hazard !== 1'b1) begin
            errors++; $display("FAIL sb_hold: got %b want 1", bus.hazard);
        end
        checks++;
        tick();
        if ({bus.reg_w, bus.rd_num, bus.hazard, bus.fwd_rs2} !== {1'b1, 5'd3, 1'b0, 1'b1}) begin
            errors++; $display("FAIL sb_clear: got %b want %b",
                {bus.reg_w, bus.rd_num, bus.hazard, bus.fwd_rs2}, {1'b1, 5'd3, 1'b0, 1'b1});
        end
        checks++;
        tick();
    endtask

    task automatic test_rd0();
        idle_inputs();
        bus.alu_valid = 1; bus.alu_rd = 0; bus.alu_data = 32'hAAAA;
        tick();
        if (bus.reg_w !== 1'b0) begin
            errors++; $display("FAIL rd0_alu: got %b want 0", bus.reg_w);
        end
        checks++;
        bus.alu_valid = 0;
        bus.lsu_valid = 1; bus.lsu_rd = 0; bus.lsu_data = 32'hBBBB;
        tick();
        bus.lsu_valid = 0;
        tick();
        if ({bus.reg_w, bus.lsu_ready, bus.lsu_full} !== 3'b010) begin
            errors++; $display("FAIL rd0_lsu: got %b want 010", {bus.reg_w, bus.lsu_ready, bus.lsu_full});
        end
        checks++;
        bus.issue_valid = 1; bus.issue_long = 1; bus.issue_rd = 0;
        tick();
        bus.issue_valid = 0;
        #1;
        if (bus.hazard !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL rd0_issue: got %h want %h", obs_vec(), exp_vec());
        end
        checks++;
    endtask

    task automatic test_collision();
        idle_inputs();
        // Result for rd 9 buffered while rd 9 is not pending
        bus.lsu_valid = 1; bus.lsu_rd = 9; bus.lsu_data = 32'h9999;
        tick();
        bus.lsu_valid = 0;
        // Pop of rd 9 coincides with a new long issue to rd 9
        bus.issue_valid = 1; bus.issue_long = 1; bus.issue_rd = 9;
        tick();
        idle_inputs();
        bus.rs1num = 9;
        #1;
        if ({bus.reg_w, bus.rd_num, bus.hazard} !== {1'b1, 5'd9, 1'b1}) begin
            errors++; $display("FAIL collision: got %b want %b",
                {bus.reg_w, bus.rd_num, bus.hazard}, {1'b1, 5'd9, 1'b1});
        end
        checks++;
        tick();
        tick();
        if (bus.hazard !== 1'b1) begin
            errors++; $display("FAIL collision_hold: got %b want 1", bus.hazard);
        end
        checks++;
        // Retire rd 9 so later scenarios start clean
        bus.lsu_valid = 1; bus.lsu_rd = 9; bus.lsu_data = 32'h9A9A;
        tick();
        bus.lsu_valid = 0;
        tick();
        #1;
        if (bus.hazard !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL collision_retire: got %h want %h", obs_vec(), exp_vec());
        end
        checks++;
    endtask

    task automatic test_random();
        for (int unsigned n = 0; n < 600; n++) begin
            rst             = ($urandom_range(0, 99) == 0);
            bus.alu_valid   = ($urandom_range(0, 9) < 4);
            bus.alu_rd      = 5'($urandom_range(0, 7));
            bus.alu_data    = $urandom;
            bus.lsu_valid   = ($urandom_range(0, 9) < 5);
            bus.lsu_rd      = 5'($urandom_range(0, 7));
            bus.lsu_data    = $urandom;
            bus.issue_valid = ($urandom_range(0, 9) < 3);
            bus.issue_long  = $urandom_range(0, 1);
            bus.issue_rd    = 5'($urandom_range(0, 7));
            bus.rs1num      = 5'($urandom_range(0, 7));
            bus.rs2num      = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            #1;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random[%0d]: got %h want %h", n, obs_vec(), exp_vec());
            end
            checks++;
            tick();
        end
        rst = 0;
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_alu_write();
        test_contention();
        test_scoreboard();
        test_rd0();
        test_collision();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
